// File: rtl/game_io_pkg.sv
// Shared constants, channel names and width helper for the game input block.
package game_io_pkg;

    localparam int unsigned DEF_NUM_BUTTONS     = 4;
    localparam int unsigned DEF_TICK_DIV        = 5_000_000;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500_000;
    localparam int unsigned DEF_ACTIVE_LOW_IN   = 1;

    // Channel order used when wiring the board KEY pins.
    typedef enum logic [1:0] {
        LEFT1  = 2'd0,
        RIGHT1 = 2'd1,
        LEFT2  = 2'd2,
        RIGHT2 = 2'd3
    } btn_idx_e;

    // Counter width able to hold values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-FF synchroniser, stability counter, debounced level and press pulse.
module btn_debounce
    import game_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic resetn,
    input  logic btn_in,      // already normalised: 1 = pressed
    output logic btn_level,
    output logic btn_press
);

    localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;

    // Next-state: synchroniser shift, accept a change only after it has been stable long enough.
    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;

        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset leaves the channel released.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign btn_level = level_q;
    assign btn_press = press_q;

endmodule

// File: rtl/game_input_ctrl.sv
// Game-tick generator, per-button debounce and per-tick latched press events.
module game_input_ctrl
    import game_io_pkg::*;
#(
    parameter int unsigned NUM_BUTTONS     = DEF_NUM_BUTTONS,
    parameter int unsigned TICK_DIV        = DEF_TICK_DIV,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned ACTIVE_LOW_IN   = DEF_ACTIVE_LOW_IN
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [NUM_BUTTONS-1:0] btn_raw,
    input  logic                   tick_en,
    output logic                   tick,
    output logic                   tick_clk,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [NUM_BUTTONS-1:0] btn_event,
    output logic [NUM_BUTTONS-1:0] btn_overrun
);

    localparam int unsigned       TICK_W    = cnt_width(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [NUM_BUTTONS-1:0] btn_norm_c;
    logic [NUM_BUTTONS-1:0] press_c;

    logic [TICK_W-1:0]      tick_cnt_q, tick_cnt_d;
    logic                   tick_q,     tick_d;
    logic                   tick_clk_q, tick_clk_d;
    logic [NUM_BUTTONS-1:0] pending_q,  pending_d;
    logic [NUM_BUTTONS-1:0] second_q,   second_d;
    logic [NUM_BUTTONS-1:0] event_q,    event_d;
    logic [NUM_BUTTONS-1:0] overrun_q,  overrun_d;

    // Normalise polarity so that 1 always means pressed before synchronisation.
    assign btn_norm_c = (ACTIVE_LOW_IN != 0) ? ~btn_raw : btn_raw;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clock     (clock),
            .resetn    (resetn),
            .btn_in    (btn_norm_c[i]),
            .btn_level (btn_level[i]),
            .btn_press (press_c[i])
        );
    end

    // Tick generator: free-running modulo counter that freezes while tick_en is low.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        tick_d     = 1'b0;
        tick_clk_d = tick_clk_q;

        if (tick_en) begin
            if (tick_cnt_q == TICK_LAST) begin
                tick_cnt_d = '0;
                tick_d     = 1'b1;
                tick_clk_d = ~tick_clk_q;
            end else begin
                tick_cnt_d = tick_cnt_q + TICK_W'(1);
            end
        end
    end

    // Event latch: a press in the tick cycle closes into the period that tick ends.
    always_comb begin
        pending_d = pending_q | press_c;
        second_d  = second_q | (pending_q & press_c);
        event_d   = event_q;
        overrun_d = overrun_q;

        if (tick_q) begin
            event_d   = pending_q | press_c;
            overrun_d = second_q | (pending_q & press_c);
            pending_d = '0;
            second_d  = '0;
        end
    end

    // State registers for tick generation and event accumulation.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
            tick_clk_q <= 1'b0;
            pending_q  <= '0;
            second_q   <= '0;
            event_q    <= '0;
            overrun_q  <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            tick_q     <= tick_d;
            tick_clk_q <= tick_clk_d;
            pending_q  <= pending_d;
            second_q   <= second_d;
            event_q    <= event_d;
            overrun_q  <= overrun_d;
        end
    end

    assign tick        = tick_q;
    assign tick_clk    = tick_clk_q;
    assign btn_press   = press_c;
    assign btn_event   = event_q;
    assign btn_overrun = overrun_q;

endmodule
